axis_pkt_arbiter_n: RTL and testbench

- N-channel AXI-Stream packet arbiter, the parametrised successor to the fixed two-channel arbiter.
- Merges P_CH_NUM upstream streams (MAC/IP/ARP/UDP layers) into one output stream.
- Uses packet-granular round-robin, with a grant lock held until the last beat.
- Adds a per-channel enable mask and a registered output stage with full back-pressure.

---
 rtl/axis_arb_pkg.sv | 37 +++
 rtl/axis_rr_pick.sv | 29 ++
 rtl/axis_pkt_arbiter_n.sv | 183 ++++++++++++++++++
 tb/tb_axis_pkt_arbiter_n.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the N-channel AXI-Stream packet arbiter:
// default widths, FSM state encoding and the round-robin pick function.
package axis_arb_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_USER_WIDTH = 80;
  localparam int DEF_KEEP_WIDTH = DEF_DATA_WIDTH / 8;
  localparam int CH_MAX         = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Returns a one-hot grant: first request found scanning upward from the
  // channel after the one-hot last grant, wrapping at n.
  function automatic logic [CH_MAX-1:0] rr_pick(
    input logic [CH_MAX-1:0] req,
    input logic [CH_MAX-1:0] last_oh,
    input int                n
  );
    logic [CH_MAX-1:0] gnt;
    logic [2:0]        idx;
    int                base;
    gnt  = '0;
    base = 0;
    for (int i = 0; i < CH_MAX; i++) begin
      if (i < n && last_oh[3'(i)]) base = i;
    end
    for (int i = 1; i <= CH_MAX; i++) begin
      if (i <= n) begin
        idx = 3'((base + i) % n);
        if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational rotate-priority encoder: picks the next requester after the
// one-hot pointer, wrapping around P_CH_NUM channels.
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int P_CH_NUM = 4
) (
  input  logic [P_CH_NUM-1:0] req,
  input  logic [P_CH_NUM-1:0] ptr,
  output logic [P_CH_NUM-1:0] gnt,
  output logic                any
);

  logic [CH_MAX-1:0] req_w;
  logic [CH_MAX-1:0] ptr_w;
  logic [CH_MAX-1:0] gnt_w;

  always_comb begin
    req_w                 = '0;
    ptr_w                 = '0;
    req_w[P_CH_NUM-1:0]   = req;
    ptr_w[P_CH_NUM-1:0]   = ptr;
    gnt_w                 = rr_pick(req_w, ptr_w, P_CH_NUM);
  end

  assign gnt = gnt_w[P_CH_NUM-1:0];
  assign any = |gnt_w;

endmodule

// File: rtl/axis_pkt_arbiter_n.sv
// N-channel AXI-Stream packet arbiter: packet-granular round-robin with a
// registered output stage. Define AXIS_ARB_STATS_EN for per-channel packet counters.
module axis_pkt_arbiter_n
  import axis_arb_pkg::*;
#(
  parameter  int P_CH_NUM     = 4,
  parameter  int P_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int P_USER_WIDTH = DEF_USER_WIDTH,
  localparam int P_KEEP_WIDTH = P_DATA_WIDTH / 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [P_CH_NUM-1:0]              i_ch_en,
  input  logic [P_CH_NUM*P_DATA_WIDTH-1:0] s_axis_data,
  input  logic [P_CH_NUM*P_USER_WIDTH-1:0] s_axis_user,
  input  logic [P_CH_NUM*P_KEEP_WIDTH-1:0] s_axis_keep,
  input  logic [P_CH_NUM-1:0]              s_axis_last,
  input  logic [P_CH_NUM-1:0]              s_axis_valid,
  output logic [P_CH_NUM-1:0]              s_axis_ready,
  output logic [P_DATA_WIDTH-1:0]          m_axis_out_data,
  output logic [P_USER_WIDTH-1:0]          m_axis_out_user,
  output logic [P_KEEP_WIDTH-1:0]          m_axis_out_keep,
  output logic                             m_axis_out_last,
  output logic                             m_axis_out_valid,
  input  logic                             m_axis_out_ready,
  output logic [P_CH_NUM-1:0]              o_grant
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [P_CH_NUM*32-1:0]           o_pkt_cnt,
  output logic                             o_pkt_active
`endif
);

  localparam logic [P_CH_NUM-1:0] PTR_RST = {1'b1, {(P_CH_NUM-1){1'b0}}};

  logic [0:0]              state_q, state_d;
  logic [P_CH_NUM-1:0]     grant_q, grant_d;
  logic [P_CH_NUM-1:0]     last_grant_q, last_grant_d;
  logic [P_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [P_USER_WIDTH-1:0] out_user_q, out_user_d;
  logic [P_KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;

  logic [P_CH_NUM-1:0]     req;
  logic [P_CH_NUM-1:0]     pick;
  logic                    pick_any;
  logic                    can_load;
  logic                    beat_fire;
  logic [P_DATA_WIDTH-1:0] sel_data;
  logic [P_USER_WIDTH-1:0] sel_user;
  logic [P_KEEP_WIDTH-1:0] sel_keep;
  logic                    sel_last;
  logic                    sel_valid;

  assign req = s_axis_valid & i_ch_en;

  axis_rr_pick #(
    .P_CH_NUM (P_CH_NUM)
  ) u_rr_pick (
    .req (req),
    .ptr (last_grant_q),
    .gnt (pick),
    .any (pick_any)
  );

  // One-hot mux of the granted channel; grant is zero outside BUSY.
  always_comb begin
    sel_data  = '0;
    sel_user  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int k = 0; k < P_CH_NUM; k++) begin
      if (grant_q[k]) begin
        sel_data  = sel_data | s_axis_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
        sel_user  = sel_user | s_axis_user[k*P_USER_WIDTH +: P_USER_WIDTH];
        sel_keep  = sel_keep | s_axis_keep[k*P_KEEP_WIDTH +: P_KEEP_WIDTH];
        sel_last  = sel_last | s_axis_last[k];
        sel_valid = sel_valid | s_axis_valid[k];
      end
    end
  end

  always_comb begin
    can_load     = ~out_valid_q | m_axis_out_ready;
    s_axis_ready = (state_q == ST_BUSY && can_load) ? grant_q : '0;
    beat_fire    = (state_q == ST_BUSY) && can_load && sel_valid;

    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d      = pick;
          last_grant_d = pick;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (beat_fire && sel_last) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (beat_fire) begin
      out_data_d  = sel_data;
      out_user_d  = sel_user;
      out_keep_d  = sel_keep;
      out_last_d  = sel_last;
      out_valid_d = 1'b1;
    end else if (m_axis_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= PTR_RST;
      out_data_q   <= '0;
      out_user_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_user_q   <= out_user_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign m_axis_out_data  = out_data_q;
  assign m_axis_out_user  = out_user_q;
  assign m_axis_out_keep  = out_keep_q;
  assign m_axis_out_last  = out_last_q;
  assign m_axis_out_valid = out_valid_q;
  assign o_grant          = grant_q;

`ifdef AXIS_ARB_STATS_EN
  logic [31:0] pkt_cnt_q [P_CH_NUM];
  logic [31:0] pkt_cnt_d [P_CH_NUM];

  // A packet counts once its last beat is accepted; counters wrap naturally.
  always_comb begin
    for (int k = 0; k < P_CH_NUM; k++) begin
      pkt_cnt_d[k] = pkt_cnt_q[k];
      if (beat_fire && sel_last && grant_q[k]) pkt_cnt_d[k] = pkt_cnt_q[k] + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int k = 0; k < P_CH_NUM; k++) pkt_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < P_CH_NUM; k++) pkt_cnt_q[k] <= pkt_cnt_d[k];
    end
  end

  always_comb begin
    o_pkt_cnt = '0;
    for (int k = 0; k < P_CH_NUM; k++) o_pkt_cnt[k*32 +: 32] = pkt_cnt_q[k];
  end

  assign o_pkt_active = (state_q == ST_BUSY);
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter_n.sv
// Self-checking bench for axis_pkt_arbiter_n: packet-level round-robin model,
// per-cycle compare process and directed scenarios.
module tb_axis_pkt_arbiter_n;

  localparam int NCH = 4;
  localparam int DW  = 64;
  localparam int UW  = 80;
  localparam int KW  = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic [NCH-1:0]    i_ch_en = '1;
  logic [NCH*DW-1:0] s_axis_data = '0;
  logic [NCH*UW-1:0] s_axis_user = '0;
  logic [NCH*KW-1:0] s_axis_keep = '0;
  logic [NCH-1:0]    s_axis_last = '0;
  logic [NCH-1:0]    s_axis_valid = '0;
  logic [NCH-1:0]    s_axis_ready;
  logic [DW-1:0]     m_axis_out_data;
  logic [UW-1:0]     m_axis_out_user;
  logic [KW-1:0]     m_axis_out_keep;
  logic              m_axis_out_last;
  logic              m_axis_out_valid;
  logic              m_axis_out_ready = 1'b1;
  logic [NCH-1:0]    o_grant;

  axis_pkt_arbiter_n #(
    .P_CH_NUM     (NCH),
    .P_DATA_WIDTH (DW),
    .P_USER_WIDTH (UW)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_ch_en          (i_ch_en),
    .s_axis_data      (s_axis_data),
    .s_axis_user      (s_axis_user),
    .s_axis_keep      (s_axis_keep),
    .s_axis_last      (s_axis_last),
    .s_axis_valid     (s_axis_valid),
    .s_axis_ready     (s_axis_ready),
    .m_axis_out_data  (m_axis_out_data),
    .m_axis_out_user  (m_axis_out_user),
    .m_axis_out_keep  (m_axis_out_keep),
    .m_axis_out_last  (m_axis_out_last),
    .m_axis_out_valid (m_axis_out_valid),
    .m_axis_out_ready (m_axis_out_ready),
    .o_grant          (o_grant)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  beat_t src_q [NCH][$];
  beat_t exp_out[$];
  int    exp_ch[$];
  beat_t out_log[$];
  int    grant_log[$];

  logic [NCH-1:0] fire_seen = '0;
  bit  checking = 0;
  bit  strict = 0;
  bit  gap_en = 0;
  bit  toggle_ready = 0;
  int  pop_cnt [NCH];
  bit  src_in_pkt [NCH];
  int  cyc = 0;

  int    last_fire_cyc;
  int    last_end_cyc;
  bit    cmp_in_pkt;
  bit    prev_hold;
  beat_t held;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Packet with traceable fields: {channel, tag, beat index, random}.
  task automatic loadPacket(input int ch, input int len, input int tag);
    beat_t b;
    for (int j = 1; j <= len; j++) begin
      b.data = {8'(ch), 8'(tag), 16'(j), 32'($urandom)};
      b.user = {16'(len), 16'(tag), 48'(j)};
      b.keep = (j == len) ? 8'hFC : 8'hFF;
      b.last = (j == len);
      src_q[ch].push_back(b);
    end
  endtask

  // Packet with repeated-byte data 0x0101.., 0x0202.., ...
  task automatic loadCounting(input int ch, input int len);
    beat_t b;
    for (int j = 1; j <= len; j++) begin
      b.data = {8{8'(j)}};
      b.user = {16'(len), 64'(j)};
      b.keep = (j == len) ? 8'hFC : 8'hFF;
      b.last = (j == len);
      src_q[ch].push_back(b);
    end
  endtask

  // Whole packets in round-robin order, starting after channel NCH-1.
  task automatic buildModel(input logic [NCH-1:0] en);
    beat_t mq [NCH][$];
    beat_t b;
    int    ptr;
    int    c;
    bit    found;
    for (int k = 0; k < NCH; k++) mq[k] = src_q[k];
    exp_out.delete();
    exp_ch.delete();
    ptr = NCH - 1;
    do begin
      found = 0;
      for (int i = 1; i <= NCH && !found; i++) begin
        c = (ptr + i) % NCH;
        if (en[c] && mq[c].size() > 0) begin
          found = 1;
          ptr   = c;
          do begin
            b = mq[c].pop_front();
            exp_out.push_back(b);
            exp_ch.push_back(c);
          end while (!b.last);
        end
      end
    end while (found);
  endtask

  task automatic applyStimulus();
    beat_t b;
    bit    popped;
    @(posedge i_clk);
    #1;
    for (int k = 0; k < NCH; k++) begin
      popped = 0;
      if (fire_seen[k] && src_q[k].size() > 0) begin
        b = src_q[k].pop_front();
        popped = 1;
        pop_cnt[k]++;
        src_in_pkt[k] = !b.last;
      end
      if (src_q[k].size() > 0 && !(gap_en && popped && src_in_pkt[k] && (cyc % 3 == 0))) begin
        s_axis_valid[k]          = 1'b1;
        s_axis_data[k*DW +: DW]  = src_q[k][0].data;
        s_axis_user[k*UW +: UW]  = src_q[k][0].user;
        s_axis_keep[k*KW +: KW]  = src_q[k][0].keep;
        s_axis_last[k]           = src_q[k][0].last;
      end else begin
        s_axis_valid[k] = 1'b0;
      end
    end
    m_axis_out_ready = toggle_ready ? ~m_axis_out_ready : 1'b1;
  endtask

  task automatic doReset();
    checking = 0;
    i_rst    = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      src_q[k].delete();
      pop_cnt[k]    = 0;
      src_in_pkt[k] = 0;
    end
    s_axis_valid = '0;
    strict       = 0;
    gap_en       = 0;
    toggle_ready = 0;
    repeat (2) applyStimulus();
    checkOutput("rst_valid", m_axis_out_valid, 0);
    checkOutput("rst_grant", o_grant, 0);
    checkOutput("rst_ready", s_axis_ready, 0);
    checkOutput("rst_out_bus", {m_axis_out_data, m_axis_out_user, m_axis_out_keep, m_axis_out_last}, 0);
    i_rst = 1'b1;
    applyStimulus();
  endtask

  task automatic startTest(input logic [NCH-1:0] en, input bit st, input bit gp, input bit tg);
    i_ch_en      = en;
    strict       = st;
    gap_en       = gp;
    toggle_ready = tg;
    buildModel(en);
    checking = 1;
  endtask

  task automatic runDrain(input int budget);
    int n;
    n = 0;
    while ((exp_out.size() > 0 || exp_ch.size() > 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_within_budget", exp_out.size() + exp_ch.size(), 0);
    toggle_ready = 0;
    repeat (5) applyStimulus();
  endtask

  // Compare process: input acceptance order, grant, bubble and output stream.
  always @(negedge i_clk) begin
    logic [NCH-1:0] fire;
    beat_t          cur;
    int             k;
    int             expk;
    cyc++;
    fire      = s_axis_valid & s_axis_ready;
    fire_seen = fire;
    cur       = {m_axis_out_data, m_axis_out_user, m_axis_out_keep, m_axis_out_last};
    if (!checking) begin
      cmp_in_pkt    = 0;
      prev_hold     = 0;
      last_end_cyc  = -100;
      last_fire_cyc = -100;
      out_log.delete();
      grant_log.delete();
    end else begin
      if (o_grant != '0) begin
        if (exp_ch.size() > 0) checkOutput("grant_vs_model", o_grant, 1 << exp_ch[0]);
        else checkOutput("grant_when_nothing_due", o_grant, 0);
      end
      if (cyc == last_end_cyc + 1) checkOutput("grant_idle_bubble", o_grant, 0);
      if (fire != '0) begin
        if ($countones(fire) != 1) begin
          checkOutput("single_accept", $countones(fire), 1);
        end else begin
          k = 0;
          for (int i = 0; i < NCH; i++) if (fire[i]) k = i;
          expk = (exp_ch.size() > 0) ? exp_ch.pop_front() : 99;
          checkOutput("accept_channel", k, expk);
          if (!cmp_in_pkt) begin
            grant_log.push_back(k);
            if (last_end_cyc > 0) begin
              if (strict) checkOutput("bubble_exact", cyc - last_end_cyc, 2);
              else checkOutput("bubble_min", (cyc - last_end_cyc) >= 2, 1);
            end
          end else if (strict) begin
            checkOutput("contiguous", cyc - last_fire_cyc, 1);
          end
          last_fire_cyc = cyc;
          cmp_in_pkt    = !s_axis_last[k];
          if (s_axis_last[k]) last_end_cyc = cyc;
        end
      end
      if (prev_hold) checkOutput("hold_stable", {m_axis_out_valid, cur}, {1'b1, held});
      if (m_axis_out_valid && m_axis_out_ready) begin
        if (exp_out.size() == 0) checkOutput("spurious_out", 1, 0);
        else checkOutput("out_beat", cur, exp_out.pop_front());
        out_log.push_back(cur);
      end
      prev_hold = m_axis_out_valid & ~m_axis_out_ready;
      held      = cur;
    end
  end

  int order3 [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int n;
    $display("[TB] start");

    // Single channel, counting pattern
    doReset();
    loadCounting(0, 10);
    startTest(4'hF, 1, 0, 0);
    runDrain(400);
    checkOutput("t1_beats", out_log.size(), 10);
    checkOutput("t1_first_data", out_log[0].data, 64'h0101010101010101);
    checkOutput("t1_last_data", out_log[9].data, 64'h0A0A0A0A0A0A0A0A);
    checkOutput("t1_last_keep", {out_log[9].keep, out_log[9].last}, {8'hFC, 1'b1});
    checkOutput("t1_first_keep", out_log[0].keep, 8'hFF);
    checkOutput("t1_user_len", out_log[0].user[79:64], 16'd10);
    checkOutput("t1_grant", {grant_log.size(), grant_log[0]}, {32'd1, 32'd0});

    // Two channels start together: no interleave
    doReset();
    loadPacket(0, 10, 1);
    loadPacket(1, 200, 2);
    startTest(4'hF, 1, 0, 0);
    runDrain(1000);
    checkOutput("t2_beats", out_log.size(), 210);
    checkOutput("t2_order", {grant_log[0], grant_log[1]}, {32'd0, 32'd1});
    checkOutput("t2_switch_beat", {out_log[9].last, out_log[10].data[63:56]}, {1'b1, 8'd1});

    // All four channels, two 3-beat packets each
    doReset();
    for (int p = 0; p < 2; p++) for (int c = 0; c < NCH; c++) loadPacket(c, 3, 10 + p);
    startTest(4'hF, 1, 0, 0);
    runDrain(400);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("t3_grant_%0d", i), grant_log[i], order3[i]);

    // Toggling downstream ready plus mid-packet valid gaps
    doReset();
    loadPacket(0, 200, 3);
    loadPacket(2, 5, 4);
    startTest(4'hF, 0, 1, 1);
    runDrain(2000);
    checkOutput("t4_beats", out_log.size(), 205);
    checkOutput("t4_last_of_c0", {out_log[199].last, out_log[199].data[47:32]}, {1'b1, 16'd200});
    checkOutput("t4_c2_first", out_log[200].data[63:56], 8'd2);

    // Channel 0 disabled; channel 1 loses enable mid-packet
    doReset();
    loadPacket(0, 4, 5);
    loadPacket(1, 20, 6);
    loadPacket(2, 4, 7);
    loadPacket(3, 4, 8);
    startTest(4'b1110, 1, 0, 0);
    repeat (8) applyStimulus();
    i_ch_en = 4'b1100;
    runDrain(600);
    repeat (6) applyStimulus();
    checkOutput("t5_order", {grant_log.size(), grant_log[0], grant_log[1], grant_log[2]},
                {32'd3, 32'd1, 32'd2, 32'd3});
    checkOutput("t5_beats", out_log.size(), 28);
    checkOutput("t5_ch0_untouched", pop_cnt[0], 0);
    checkOutput("t5_idle_grant", o_grant, 0);

    // Reset in the middle of a packet
    doReset();
    loadCounting(0, 10);
    startTest(4'hF, 1, 0, 0);
    n = 0;
    while (pop_cnt[0] < 5 && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("t6_reached_beat5", pop_cnt[0] >= 5, 1);
    checking = 0;
    i_rst    = 1'b0;
    applyStimulus();
    checkOutput("t6_rst_valid", m_axis_out_valid, 0);
    checkOutput("t6_rst_grant", o_grant, 0);
    checkOutput("t6_rst_ready", s_axis_ready, 0);
    for (int k = 0; k < NCH; k++) begin
      src_q[k].delete();
      pop_cnt[k]    = 0;
      src_in_pkt[k] = 0;
    end
    s_axis_valid = '0;
    applyStimulus();
    i_rst = 1'b1;
    applyStimulus();
    loadCounting(0, 10);
    startTest(4'hF, 1, 0, 0);
    runDrain(400);
    checkOutput("t6_beats", out_log.size(), 10);
    checkOutput("t6_first_data", out_log[0].data, 64'h0101010101010101);
    checkOutput("t6_grant", {grant_log.size(), grant_log[0]}, {32'd1, 32'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
